// File: rtl/mux_select_arbiter_if.sv
// Handshake bundle between the four requesters and the arbiter
// that drives the shared 4:1 mux select lines.
interface mux_select_arbiter_if #(
  parameter int CNT_W = 4
);
  logic [3:0]       req;
  logic [3:0]       grant;
  logic             address0;
  logic             address1;
  logic             busy;
  logic [CNT_W-1:0] burst_cnt;

  modport master (
    output req,
    input  grant, address0, address1, busy, burst_cnt
  );

  modport slave (
    input  req,
    output grant, address0, address1, busy, burst_cnt
  );
endinterface

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux with a bounded burst length;
// every output is registered, so nothing depends combinationally on req.
module mux_select_arbiter #(
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mux_select_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       addr_q, addr_d;
  logic [1:0]       last_ptr_q, last_ptr_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [1:0]       scan_ptr;
  logic [2:0]       pick;
  logic             rearb;

  // Returns {found, index} of the first set request after ptr, wrapping to ptr last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] c;
    res = '0;
    for (int k = 1; k <= 4; k++) begin
      c = ptr + 2'(k);
      if (!res[2] && r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  // While granted, a release rescans from the current owner, which is addr_q.
  always_comb begin
    scan_ptr = (state_q == GRANT) ? addr_q : last_ptr_q;
    pick     = rr_pick(bus.req, scan_ptr);
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    last_ptr_d  = last_ptr_q;
    busy_d      = busy_q;
    burst_cnt_d = burst_cnt_q;
    rearb       = 1'b0;

    case (state_q)
      IDLE: rearb = 1'b1;
      GRANT: begin
        if (bus.req[addr_q] && (burst_cnt_q < CNT_W'(BURST_MAX))) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end else begin
          last_ptr_d = addr_q;
          rearb      = 1'b1;
        end
      end
      default: rearb = 1'b1;
    endcase

    // Address is deliberately left alone when going idle so the mux select does not toggle.
    if (rearb) begin
      if (pick[2]) begin
        state_d     = GRANT;
        grant_d     = 4'b0001 << pick[1:0];
        addr_d      = pick[1:0];
        busy_d      = 1'b1;
        burst_cnt_d = CNT_W'(1);
      end else begin
        state_d     = IDLE;
        grant_d     = '0;
        busy_d      = 1'b0;
        burst_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      addr_q      <= '0;
      last_ptr_q  <= 2'd3;
      busy_q      <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      last_ptr_q  <= last_ptr_d;
      busy_q      <= busy_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.address0  = addr_q[0];
  assign bus.address1  = addr_q[1];
  assign bus.busy      = busy_q;
  assign bus.burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Directed and randomized checks of the round-robin mux select arbiter,
// including burst limit, handover, idle hold, wrap-around and async reset.
module tb_mux_select_arbiter;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  int   wait_cnt [4];

  mux_select_arbiter_if #(.CNT_W(4)) bus ();

  mux_select_arbiter #(.BURST_MAX(4), .CNT_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] g, input logic [1:0] a,
                          input logic b, input logic [3:0] c);
    checkOutput({tag, ".grant"}, 32'(bus.grant), 32'(g));
    checkOutput({tag, ".addr"}, 32'({bus.address1, bus.address0}), 32'(a));
    checkOutput({tag, ".busy"}, 32'(bus.busy), 32'(b));
    checkOutput({tag, ".cnt"}, 32'(bus.burst_cnt), 32'(c));
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    bus.req = r;
  endtask

  // Advance to just after the next rising edge, where outputs are sampled.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    logic [1:0] idx;
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    bus.req = 4'b0000;

    #12;
    checkAll("reset", 4'b0000, 2'b00, 1'b0, 4'd0);
    reset_n = 1'b1;

    $display("[TB] sole requester 2 with burst limit");
    applyStimulus(4'b0100);
    stepClock();
    checkAll("t1.c1", 4'b0100, 2'b10, 1'b1, 4'd1);
    stepClock();
    stepClock();
    stepClock();
    checkAll("t1.c4", 4'b0100, 2'b10, 1'b1, 4'd4);
    stepClock();
    checkAll("t1.regrant", 4'b0100, 2'b10, 1'b1, 4'd1);

    $display("[TB] all four requesting after reset");
    pulseReset();
    applyStimulus(4'b1111);
    for (int i = 0; i < 16; i++) begin
      stepClock();
      checkAll("t2.rr", 4'(4'b0001 << (i / 4)), 2'(i / 4), 1'b1, 4'((i % 4) + 1));
    end

    $display("[TB] owner drops mid-burst, handover to 3");
    pulseReset();
    applyStimulus(4'b0010);
    stepClock();
    checkAll("t3.g1", 4'b0010, 2'b01, 1'b1, 4'd1);
    stepClock();
    checkAll("t3.c2", 4'b0010, 2'b01, 1'b1, 4'd2);
    applyStimulus(4'b1000);
    stepClock();
    checkAll("t3.hand", 4'b1000, 2'b11, 1'b1, 4'd1);

    $display("[TB] release to idle, address hold, wrap-around");
    applyStimulus(4'b0000);
    stepClock();
    checkAll("t4.idle", 4'b0000, 2'b11, 1'b0, 4'd0);
    stepClock();
    checkAll("t4.idle2", 4'b0000, 2'b11, 1'b0, 4'd0);
    applyStimulus(4'b1001);
    stepClock();
    checkAll("t4.wrap", 4'b0001, 2'b00, 1'b1, 4'd1);

    $display("[TB] asynchronous reset mid-grant");
    applyStimulus(4'b0010);
    stepClock();
    checkAll("t5.g1", 4'b0010, 2'b01, 1'b1, 4'd1);
    stepClock();
    stepClock();
    checkAll("t5.c3", 4'b0010, 2'b01, 1'b1, 4'd3);
    #2;
    reset_n = 1'b0;
    #1;
    checkAll("t5.async", 4'b0000, 2'b00, 1'b0, 4'd0);
    applyStimulus(4'b0011);
    #1;
    reset_n = 1'b1;
    stepClock();
    checkAll("t5.after", 4'b0001, 2'b00, 1'b1, 4'd1);

    $display("[TB] randomized requests with invariant checks");
    pulseReset();
    applyStimulus(4'b0000);
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      stepClock();
      checkOutput("rnd.onehot", 32'($onehot0(bus.grant)), 32'd1);
      checkOutput("rnd.busy", 32'(bus.busy), 32'(|bus.grant));
      checkOutput("rnd.cntmax", 32'(bus.burst_cnt <= 4'd4), 32'd1);
      if (bus.busy) begin
        idx = 2'd0;
        for (int i = 0; i < 4; i++) if (bus.grant[i]) idx = 2'(i);
        checkOutput("rnd.addr", 32'({bus.address1, bus.address0}), 32'(idx));
      end
      for (int i = 0; i < 4; i++) begin
        if (bus.req[i] && !bus.grant[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        checkOutput("rnd.wait", 32'(wait_cnt[i] <= 12), 32'd1);
      end
      r = bus.req;
      for (int i = 0; i < 4; i++) begin
        if (bus.grant[i])  r[i] = ($urandom_range(0, 3) != 0);
        else if (!r[i])    r[i] = ($urandom_range(0, 2) == 0);
      end
      applyStimulus(r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
